assign_in_checker: RTL and testbench
====================================

// Module: assign_in_checker
// PURPOSE
//   Self-checking scoreboard stage placed directly downstream of the forced-input/pass-through
//   pair in the ASSIGNIN regression. Samples the pair's outputs (oa, oz) every cycle and compares
//   them against expected values derived from the stimulus bit i. Keeps mismatch statistics and
//   reports a single done/pass verdict so the top-level test can call $finish or $stop.
// PARAMETERS
//   CNT_W          32  width of cycle counter, error counter and error timestamp
//   LAT             1  cycles from i to oz at checker inputs (>=1); expected oz = i delayed LAT
//   EXP_OA       1'b1  constant expected value of oa (input forced inside producer)
//   SETTLE_CYCLES   2  cycles after start during which compares are masked (>=0)
//   RUN_CYCLES      8  cycles of active checking (>=1)
// PORTS
//   clk            in   1      clock, all state on posedge
//   rst            in   1      synchronous, active-high reset
//   start          in   1      begin check sequence (sampled only in IDLE)
//   i              in   1      stimulus bit driven into producer this cycle
//   oa             in   1      producer output under forced input
//   oz             in   1      producer pass-through output
//   done           out  1      sequence complete, held until rst
//   pass           out  1      valid when done: 1 iff err_count==0
//   err_count      out  CNT_W  saturating count of mismatching RUN cycles
//   first_err_cyc  out  CNT_W  cyc value of first mismatch; all-ones if none
//   cyc            out  CNT_W  free cycle counter
//   state          out  2      FSM state: 0 IDLE, 1 SETTLE, 2 RUN, 3 DONE
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, cyc=0, err_count=0, first_err_cyc='1, done=0, pass=0,
//     expected shift register cleared to 0. Reset mid-sequence aborts immediately, no verdict.
//   cyc: +1 every cycle state!=DONE; saturates at all-ones; frozen in DONE.
//   exp_sr: LAT-deep shift register, exp_sr[0]<=i every cycle in all states; exp_oz=exp_sr[LAT-1].
//   FSM transitions (evaluated at posedge, rst has priority):
//     IDLE   -> SETTLE when start=1 (-> RUN directly if SETTLE_CYCLES==0); else stay.
//     SETTLE -> RUN after exactly SETTLE_CYCLES cycles in SETTLE (down-counter loaded on entry).
//     RUN    -> DONE after exactly RUN_CYCLES cycles in RUN (each RUN cycle is checked).
//     DONE   -> stays until rst; start ignored.
//   Check (RUN only): mismatch = (oa !== EXP_OA) || (oz !== exp_oz), 4-state compare.
//     On mismatch: err_count+1 (saturating at all-ones); if first_err_cyc=='1, it takes cyc.
//     SETTLE/IDLE/DONE mismatches never counted.
//   Outputs registered: done=1 and pass=(err_count_final==0) from first DONE cycle;
//     a mismatch on the last RUN cycle is included in pass.
//   Latency: done rises SETTLE_CYCLES+RUN_CYCLES+1 posedges after start is sampled.
//   start held high or pulsed: equivalent; start=1 during rst ignored.
// TESTING
//   T1 clean: rst 3 cyc, start 1 cyc, i=cyc[0], oa=1, oz=i delayed 1 -> done after 11 edges,
//      pass=1, err_count=0, first_err_cyc=32'hFFFF_FFFF.
//   T2 oa fault: force oa=0 for 1 cycle in 3rd RUN cycle -> err_count=1, pass=0,
//      first_err_cyc = cyc of that cycle.
//   T3 masking: oz wrong during all SETTLE cycles only -> err_count=0, pass=1.
//   T4 edge: oz wrong only on last RUN cycle -> done with pass=0, err_count=1.
//   T5 reset mid-RUN with 2 errors logged -> next cycle state=IDLE, err_count=0, done=0;
//      restart clean -> pass=1.
//   T6 saturation: CNT_W=3, RUN_CYCLES=12, oz always wrong -> err_count=7, cyc stops at 7.

Source files
------------

// File: rtl/assign_in_checker.sv
// Scoreboard stage for the forced-input / pass-through pair: checks oa against a constant
// and oz against the stimulus delayed LAT cycles, then latches a done/pass verdict.
module assign_in_checker #(
  parameter int       CNT_W         = 32,
  parameter int       LAT           = 1,
  parameter logic     EXP_OA        = 1'b1,
  parameter int       SETTLE_CYCLES = 2,
  parameter int       RUN_CYCLES    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             i,
  input  logic             oa,
  input  logic             oz,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [CNT_W-1:0] cyc,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;

  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam int RW = $clog2(RUN_CYCLES + 2);

  state_e           state_q;
  logic [SW-1:0]    set_cnt_q;
  logic [RW-1:0]    run_cnt_q;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             done_q, pass_q;
  logic [LAT-1:0]   exp_sr_q;
  logic             exp_oz, mismatch;

  assign exp_oz   = exp_sr_q[LAT-1];
  // 4-state compare so an X/Z on either producer output counts as a mismatch
  assign mismatch = (oa !== EXP_OA) || (oz !== exp_oz);

  always_comb begin
    cyc_d   = cyc_q;
    err_d   = err_q;
    first_d = first_q;
    if (state_q != DONE && cyc_q != '1)
      cyc_d = cyc_q + CNT_W'(1);
    if (state_q == RUN && mismatch) begin
      if (err_q != '1)   err_d   = err_q + CNT_W'(1);
      if (first_q == '1) first_d = cyc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      set_cnt_q <= '0;
      run_cnt_q <= '0;
      cyc_q     <= '0;
      err_q     <= '0;
      first_q   <= '1;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      exp_sr_q  <= '0;
    end else begin
      exp_sr_q[0] <= i;
      for (int k = 1; k < LAT; k++) exp_sr_q[k] <= exp_sr_q[k-1];
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      first_q <= first_d;
      case (state_q)
        IDLE: if (start) begin
          if (SETTLE_CYCLES == 0) begin
            state_q   <= RUN;
            run_cnt_q <= RW'(RUN_CYCLES);
          end else begin
            state_q   <= SETTLE;
            set_cnt_q <= SW'(SETTLE_CYCLES);
          end
        end
        SETTLE: begin
          if (set_cnt_q == SW'(1)) begin
            state_q   <= RUN;
            run_cnt_q <= RW'(RUN_CYCLES);
          end else begin
            set_cnt_q <= set_cnt_q - SW'(1);
          end
        end
        RUN: begin
          // verdict uses err_d so a miss on the final RUN cycle is not lost
          if (run_cnt_q == RW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            run_cnt_q <= run_cnt_q - RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_cyc = first_q;
  assign cyc           = cyc_q;
  assign state         = state_q;

endmodule

// File: tb/tb_assign_in_checker.sv
// Bench for assign_in_checker: phase-by-elapsed-cycles model checked every cycle,
// directed fault scenarios with literal expectations, and a narrow-counter saturation instance.
module tb_assign_in_checker;
  localparam int S = 2;
  localparam int R = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, i = 1'b0, oa = 1'b1, oz = 1'b0;
  logic done, pass;
  logic [31:0] err_count, first_err_cyc, cyc;
  logic [1:0] state;

  assign_in_checker dut (
    .clk(clk), .rst(rst), .start(start), .i(i), .oa(oa), .oz(oz),
    .done(done), .pass(pass), .err_count(err_count), .first_err_cyc(first_err_cyc),
    .cyc(cyc), .state(state)
  );

  logic rst2 = 1'b1, start2 = 1'b0, i2 = 1'b0, oa2 = 1'b1, oz2 = 1'b0;
  logic done2, pass2;
  logic [2:0] err2, first2, cyc2;
  logic [1:0] state2;

  assign_in_checker #(.CNT_W(3), .RUN_CYCLES(12)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .i(i2), .oa(oa2), .oz(oz2),
    .done(done2), .pass(pass2), .err_count(err2), .first_err_cyc(first2),
    .cyc(cyc2), .state(state2)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Phase of the cycle from edges elapsed since start was accepted
  function automatic int phase(input bit st, input int nn);
    if (!st) return 0;
    if (nn <= S) return 1;
    if (nn <= S + R) return 2;
    return 3;
  endfunction

  bit armed = 0, started = 0;
  int n = 0;
  logic [31:0] m_cyc = '0, m_err = '0, m_first = '1;
  bit m_done = 0, m_pass = 0;
  bit q[$];

  always @(posedge clk) begin
    if (rst) begin
      armed = 1; started = 0; n = 0;
      m_cyc = '0; m_err = '0; m_first = '1; m_done = 0; m_pass = 0;
      q.delete();
      q.push_back(1'b0);
    end else if (armed) begin : mdl
      int ph;
      ph = phase(started, n);
      if (ph == 2 && (oa !== 1'b1 || oz !== q[0])) begin
        if (m_err != '1) m_err++;
        if (m_first == '1) m_first = m_cyc;
      end
      if (ph != 3 && m_cyc != '1) m_cyc++;
      if (ph == 2 && n == S + R) begin
        m_done = 1;
        m_pass = (m_err == 0);
      end
      if (started) n++;
      else if (start) begin started = 1; n = 1; end
      void'(q.pop_front());
      q.push_back(i);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("state", state, phase(started, n));
      chk("cyc", cyc, m_cyc);
      chk("err_count", err_count, m_err);
      chk("first_err_cyc", first_err_cyc, m_first);
      chk("done", done, m_done);
      chk("pass", pass, m_pass);
    end
  end

  bit prev = 0;

  task automatic run_seq(input int fault, input bit do_rst);
    prev = 0; i = 0; oa = 1; oz = 0; start = 0;
    if (do_rst) begin
      rst = 1;
      if (fault == 3) start = 1;
      repeat (3) @(negedge clk);
    end
    rst = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int j = 1; j <= S + R; j++) begin
      bit iv;
      if (fault == 5 && j == S + 4) begin
        chk("t5_err_before_rst", err_count, 2);
        rst = 1; i = 0; oz = 0;
        @(negedge clk);
        chk("t5_state_idle", state, 0);
        chk("t5_err_cleared", err_count, 0);
        chk("t5_done_low", done, 0);
        return;
      end
      iv = 1'($urandom_range(0, 1));
      i = iv; oa = 1; oz = prev; prev = iv;
      if (fault == 2 && j == S + 3) oa = 0;
      if (fault == 3 && j <= S) oz = ~oz;
      if (fault == 4 && j == S + R) oz = ~oz;
      if (fault == 5 && (j == S + 1 || j == S + 2)) oz = ~oz;
      if (j == S + R) chk("latency_not_yet", done, 0);
      @(negedge clk);
    end
    chk("done_at_11", done, 1);
    chk("cyc_at_done", cyc, 11);
    case (fault)
      2: begin chk("t2_err", err_count, 1); chk("t2_pass", pass, 0); chk("t2_first", first_err_cyc, 5); end
      4: begin chk("t4_err", err_count, 1); chk("t4_pass", pass, 0); chk("t4_first", first_err_cyc, 10); end
      default: begin
        chk("clean_err", err_count, 0);
        chk("clean_pass", pass, 1);
        chk("clean_first", first_err_cyc, 32'hFFFF_FFFF);
      end
    endcase
    start = 1;
    repeat (2) @(negedge clk);
    chk("done_hold_state", state, 3);
    chk("done_hold_cyc", cyc, 11);
    start = 0;
  endtask

  initial begin
    run_seq(1, 1);
    run_seq(2, 1);
    run_seq(3, 1);
    run_seq(4, 1);
    run_seq(5, 1);
    run_seq(0, 0);

    rst = 1;
    rst2 = 1;
    repeat (3) @(negedge clk);
    rst2 = 0; start2 = 1; i2 = 0; oa2 = 1; oz2 = 1;
    repeat (20) @(negedge clk);
    chk("t6_err_sat", err2, 7);
    chk("t6_cyc_sat", cyc2, 7);
    chk("t6_done", done2, 1);
    chk("t6_pass", pass2, 0);
    chk("t6_first", first2, 3);
    chk("t6_state", state2, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
